// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: one outstanding imem request at a time, a prefetch FIFO of
// {pc, instruction} pairs toward decode, and flush/restart on redirect.
module fetch_prefetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    imem_req,
  output logic [XLEN-1:0]         imem_addr,
  input  logic                    imem_ack,
  input  logic [31:0]             imem_rdata,
  input  logic                    redirect,
  input  logic [XLEN-1:0]         redirect_pc,
  output logic                    instr_valid,
  input  logic                    instr_ready,
  output logic [31:0]             instr_out,
  output logic [XLEN-1:0]         instr_pc,
  output logic [XLEN-1:0]         instr_pc_plus4,
  output logic [$clog2(DEPTH):0]  occupancy
);

  localparam int unsigned    PtrW     = $clog2(DEPTH);
  localparam int unsigned    CntW     = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  logic [XLEN-1:0] fetchPcQ, fetchPcD;
  logic [XLEN-1:0] reqAddrQ, reqAddrD;
  logic            inFlightQ, inFlightD;
  logic            dropQ, dropD;
  logic [PtrW-1:0] wrPtrQ, wrPtrD, rdPtrQ, rdPtrD;
  logic [CntW-1:0] countQ, countD;

  logic [XLEN-1:0] pcMem    [DEPTH];
  logic [31:0]     instrMem [DEPTH];

  logic respond, push, pop, stall;

  // A new request only issues when the queue has room for its response; once raised it
  // holds with its latched address until acknowledged, even across a redirect.
  assign imem_req  = !reset && (inFlightQ || (countQ < DepthCnt));
  assign imem_addr = inFlightQ ? reqAddrQ : fetchPcQ;

  assign respond = imem_req && imem_ack;
  assign stall   = imem_req && !imem_ack;
  assign push    = respond && !dropQ && !redirect;
  assign pop     = instr_valid && instr_ready && !redirect;

  assign instr_valid    = countQ != '0;
  assign occupancy      = countQ;
  assign instr_out      = instrMem[rdPtrQ];
  assign instr_pc       = pcMem[rdPtrQ];
  assign instr_pc_plus4 = instr_pc + XLEN'(4);

  always_comb begin
    fetchPcD  = fetchPcQ;
    reqAddrD  = reqAddrQ;
    inFlightD = stall;
    dropD     = dropQ;
    wrPtrD    = wrPtrQ;
    rdPtrD    = rdPtrQ;
    countD    = countQ;

    if (stall) reqAddrD = imem_addr;
    if (respond) dropD = 1'b0;

    if (push) begin
      fetchPcD = fetchPcQ + XLEN'(4);
      wrPtrD   = wrPtrQ + PtrW'(1);
    end
    if (pop) rdPtrD = rdPtrQ + PtrW'(1);

    unique case ({push, pop})
      2'b10:   countD = countQ + CntW'(1);
      2'b01:   countD = countQ - CntW'(1);
      default: countD = countQ;
    endcase

    // Redirect wins: flush, retarget, and mark a still-pending old response for discard.
    if (redirect) begin
      fetchPcD = redirect_pc & ~XLEN'(3);
      dropD    = stall;
      wrPtrD   = '0;
      rdPtrD   = '0;
      countD   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetchPcQ  <= RESET_PC;
      reqAddrQ  <= RESET_PC;
      inFlightQ <= 1'b0;
      dropQ     <= 1'b0;
      wrPtrQ    <= '0;
      rdPtrQ    <= '0;
      countQ    <= '0;
    end else begin
      fetchPcQ  <= fetchPcD;
      reqAddrQ  <= reqAddrD;
      inFlightQ <= inFlightD;
      dropQ     <= dropD;
      wrPtrQ    <= wrPtrD;
      rdPtrQ    <= rdPtrD;
      countQ    <= countD;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pcMem[wrPtrQ]    <= imem_addr;
      instrMem[wrPtrQ] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: directed table, corner sequences, and randomized traffic
// checked every cycle against a queue-based reference model.
module tb_fetch_prefetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;
  logic [2:0]  occupancy;

  fetch_prefetch_unit #(
    .XLEN(32),
    .DEPTH(DEPTH),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_out(instr_out),
    .instr_pc(instr_pc),
    .instr_pc_plus4(instr_pc_plus4),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: delivered pairs held in a plain queue.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t      mQ[$];
  logic [31:0] mFetchPc = '0;
  logic [31:0] mReqAddr = '0;
  logic        mInFlight = 1'b0;
  logic        mDrop = 1'b0;

  // Outputs sampled in the most recent step.
  logic        sReq, sValid;
  logic [31:0] sAddr, sPc, sPc4, sInstr;
  logic [2:0]  sOcc;

  typedef struct {
    logic        rdy;
    logic        eReq;
    logic [31:0] eAddr;
    logic        eValid;
    logic [31:0] ePc;
    logic [2:0]  eOcc;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic modelReq(input logic rst);
    return !rst && (mInFlight || (mQ.size() < DEPTH));
  endfunction

  function automatic logic [31:0] modelAddr();
    return mInFlight ? mReqAddr : mFetchPc;
  endfunction

  // One clock cycle: drive at negedge, sample and compare, then advance the model at posedge.
  task automatic step(input logic a, input logic [31:0] d, input logic rd, input logic [31:0] rpc,
                      input logic rdy, input logic rst);
    logic        eReq;
    logic [31:0] eAddr;
    entry_t      ent;
    reset = rst; imem_ack = a; imem_rdata = d; redirect = rd; redirect_pc = rpc;
    instr_ready = rdy;
    #1;
    eReq  = modelReq(rst);
    eAddr = modelAddr();
    sReq = imem_req; sAddr = imem_addr; sValid = instr_valid; sPc = instr_pc;
    sPc4 = instr_pc_plus4; sInstr = instr_out; sOcc = occupancy;
    check("model_req", sReq, eReq);
    if (eReq) check("model_addr", sAddr, eAddr);
    check("model_valid", sValid, mQ.size() != 0);
    check("model_occ", sOcc, mQ.size());
    if (mQ.size() != 0) begin
      check("model_pc", sPc, mQ[0].pc);
      check("model_instr", sInstr, mQ[0].instr);
      check("model_pc4", sPc4, mQ[0].pc + 32'd4);
    end
    @(posedge clk);
    if (rst) begin
      mQ.delete(); mFetchPc = '0; mInFlight = 1'b0; mDrop = 1'b0;
    end else if (rd) begin
      mQ.delete();
      mFetchPc  = {rpc[31:2], 2'b00};
      mDrop     = eReq && !a;
      mInFlight = eReq && !a;
      if (mInFlight) mReqAddr = eAddr;
    end else begin
      if (mQ.size() != 0 && rdy) mQ.delete(0);
      if (eReq && a) begin
        if (mDrop) mDrop = 1'b0;
        else begin
          ent.pc = eAddr; ent.instr = d;
          mQ.push_back(ent);
          mFetchPc = mFetchPc + 32'd4;
        end
      end
      mInFlight = eReq && !a;
      if (mInFlight) mReqAddr = eAddr;
    end
    @(negedge clk);
  endtask

  task automatic zw(input logic rdy);
    step(1'b1, modelAddr() ^ 32'hA5A5_0000, 1'b0, 32'h0, rdy, 1'b0);
  endtask

  task automatic doReset();
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int  cnt, dly;
    logic started8, redirDone, pendOld, needNext, t3Done;

    // Full-queue scenario, zero-wait memory, ready pulsed for one cycle.
    vecs[0] = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h0, 3'd0};
    vecs[1] = '{1'b0, 1'b1, 32'h04, 1'b1, 32'h0, 3'd1};
    vecs[2] = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h0, 3'd2};
    vecs[3] = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h0, 3'd3};
    vecs[4] = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h0, 3'd4};
    vecs[5] = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h0, 3'd4};
    vecs[6] = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h4, 3'd3};
    vecs[7] = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h4, 3'd4};

    @(negedge clk);
    doReset();
    check("reset_req", sReq, 1'b0);
    check("reset_valid", sValid, 1'b0);
    for (int i = 0; i < 8; i++) begin
      zw(vecs[i].rdy);
      check("tbl_req", sReq, vecs[i].eReq);
      if (vecs[i].eReq) check("tbl_addr", sAddr, vecs[i].eAddr);
      check("tbl_valid", sValid, vecs[i].eValid);
      check("tbl_occ", sOcc, vecs[i].eOcc);
      if (vecs[i].eValid) begin
        check("tbl_pc", sPc, vecs[i].ePc);
        check("tbl_instr", sInstr, vecs[i].ePc ^ 32'hA5A5_0000);
        check("tbl_pc4", sPc4, vecs[i].ePc + 32'd4);
      end
    end

    // 3-wait memory; redirect to 0x103 one cycle after the request to 0x8 starts.
    doReset();
    cnt = 0; started8 = 0; redirDone = 0; pendOld = 0; needNext = 0; t3Done = 0;
    for (int c = 0; c < 80; c++) begin
      logic r, a, rdc, first8;
      logic [31:0] ad;
      r = modelReq(1'b0); ad = modelAddr();
      a = r && (cnt == 3);
      first8 = r && (ad == 32'h8) && (cnt == 0);
      rdc = started8 && !redirDone;
      step(a, ad ^ 32'hA5A5_0000, rdc, 32'h0000_0103, 1'b1, 1'b0);
      if (r) cnt = a ? 0 : cnt + 1;
      if (first8) started8 = 1;
      if (rdc) begin
        redirDone = 1; pendOld = !a;
      end else if (pendOld) begin
        check("t3_hold_addr", sAddr, 32'h8);
        if (a) begin pendOld = 0; needNext = 1; end
      end else if (needNext && sReq) begin
        check("t3_next_addr", sAddr, 32'h100);
        needNext = 0;
      end
      if (redirDone && !rdc && sValid) begin
        check("t3_first_pc", sPc, 32'h100);
        t3Done = 1;
        break;
      end
    end
    check("t3_complete", t3Done, 1'b1);

    // Two entries queued; redirect, ready and ack all in one cycle.
    doReset();
    zw(1'b0); zw(1'b0);
    step(1'b1, modelAddr() ^ 32'hA5A5_0000, 1'b1, 32'h0000_0200, 1'b1, 1'b0);
    check("t4_occ_before", sOcc, 3'd2);
    zw(1'b0);
    check("t4_occ_after", sOcc, 3'd0);
    check("t4_valid_after", sValid, 1'b0);
    check("t4_addr_after", sAddr, 32'h200);
    zw(1'b1);
    check("t4_first_pc", sPc, 32'h200);

    // PC wrap at the top of the address space.
    doReset();
    zw(1'b1);
    step(1'b1, modelAddr() ^ 32'hA5A5_0000, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0);
    zw(1'b1);
    check("t5_addr", sAddr, 32'hFFFF_FFFC);
    zw(1'b1);
    check("t5_pc0", sPc, 32'hFFFF_FFFC);
    check("t5_pc4", sPc4, 32'h0000_0000);
    zw(1'b1);
    check("t5_pc1", sPc, 32'h0000_0000);

    // Randomized traffic against the model.
    doReset();
    dly = -1;
    for (int c = 0; c < 3000; c++) begin
      logic rst, r, a, rd, rdy;
      rst = ($urandom_range(0, 499) == 0);
      r = modelReq(rst);
      a = 1'b0;
      if (rst) dly = -1;
      else if (r) begin
        if (dly < 0) dly = $urandom_range(0, 5);
        a = (dly == 0);
        dly = a ? -1 : dly - 1;
      end
      rd  = ($urandom_range(0, 15) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      step(a, $urandom, rd, $urandom, rdy, rst);
      check("occ_bound", sOcc <= DEPTH, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
